// File: rtl/result_accumulator.sv
// Accumulates BLOCK_LEN unsigned words into a sum (mod 2^32), a maximum and a carry-out flag,
// then presents the block result with a ready/valid style handshake on both sides.
module result_accumulator #(
    parameter int unsigned BLOCK_LEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_sync,
    output logic        in_notify,
    output logic [31:0] sum_out,
    output logic [31:0] max_out,
    output logic        ovf_out,
    input  logic        out_sync,
    output logic        out_notify
);

    localparam logic [7:0] LP_LEN = 8'(BLOCK_LEN);

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_in_notify;
    logic        r_out_notify;
    logic [31:0] r_acc;
    logic [31:0] r_max_acc;
    logic        r_ovf_acc;
    logic [7:0]  r_cnt;
    logic [31:0] r_sum;
    logic [31:0] r_max;
    logic        r_ovf;

    logic [32:0] w_sum33;
    logic [31:0] w_max_next;
    logic        w_ovf_next;
    logic [7:0]  w_cnt_next;
    logic        w_in_xfer;
    logic        w_out_xfer;

    function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
        return (b > a) ? b : a;
    endfunction

    assign w_sum33    = {1'b0, r_acc} + {1'b0, in_data};
    assign w_max_next = umax(r_max_acc, in_data);
    assign w_ovf_next = r_ovf_acc | w_sum33[32];
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_in_xfer  = in_sync & r_in_notify;
    assign w_out_xfer = out_sync & r_out_notify;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RECV;
            r_in_notify  <= 1'b1;
            r_out_notify <= 1'b0;
            r_acc        <= '0;
            r_max_acc    <= '0;
            r_ovf_acc    <= 1'b0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_max        <= '0;
            r_ovf        <= 1'b0;
        end else if (r_state == RECV) begin
            if (w_in_xfer) begin
                r_acc     <= w_sum33[31:0];
                r_max_acc <= w_max_next;
                r_ovf_acc <= w_ovf_next;
                r_cnt     <= w_cnt_next;
                // Last word of the block: publish the updated values on this same edge.
                if (w_cnt_next == LP_LEN) begin
                    r_sum        <= w_sum33[31:0];
                    r_max        <= w_max_next;
                    r_ovf        <= w_ovf_next;
                    r_state      <= SEND;
                    r_in_notify  <= 1'b0;
                    r_out_notify <= 1'b1;
                end
            end
        end else begin
            if (w_out_xfer) begin
                r_state      <= RECV;
                r_in_notify  <= 1'b1;
                r_out_notify <= 1'b0;
                r_acc        <= '0;
                r_max_acc    <= '0;
                r_ovf_acc    <= 1'b0;
                r_cnt        <= '0;
            end
        end
    end

    assign in_notify  = r_in_notify;
    assign out_notify = r_out_notify;
    assign sum_out    = r_sum;
    assign max_out    = r_max;
    assign ovf_out    = r_ovf;

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: directed scenarios plus randomized traffic against a block-level model.
module tb_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sync;
    logic        out_sync;
    logic        in_notify;
    logic        out_notify;
    logic [31:0] sum_out;
    logic [31:0] max_out;
    logic        ovf_out;

    logic [31:0] d1_in_data;
    logic        d1_in_sync;
    logic        d1_out_sync;
    logic        d1_in_notify;
    logic        d1_out_notify;
    logic [31:0] d1_sum_out;
    logic [31:0] d1_max_out;
    logic        d1_ovf_out;

    int checks = 0;
    int errors = 0;

    // Model of the 5-word instance: collected words and expected output registers.
    bit          m_pend;
    logic [31:0] m_q[$];
    logic [31:0] m_sum;
    logic [31:0] m_max;
    logic        m_ovf;

    always #5 clk = ~clk;

    result_accumulator #(.BLOCK_LEN(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sync(in_sync), .in_notify(in_notify),
        .sum_out(sum_out), .max_out(max_out), .ovf_out(ovf_out),
        .out_sync(out_sync), .out_notify(out_notify)
    );

    result_accumulator #(.BLOCK_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_sync(d1_in_sync), .in_notify(d1_in_notify),
        .sum_out(d1_sum_out), .max_out(d1_max_out), .ovf_out(d1_ovf_out),
        .out_sync(d1_out_sync), .out_notify(d1_out_notify)
    );

    // Block result from plain arithmetic: a carry happened somewhere iff the true total reaches 2^32.
    task automatic model_block();
        longint unsigned total = 0;
        logic [31:0] mx = 0;
        foreach (m_q[i]) begin
            total += longint'(m_q[i]);
            if (m_q[i] > mx) mx = m_q[i];
        end
        m_sum = total[31:0];
        m_max = mx;
        m_ovf = (total >> 32) != 0;
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] d, input logic o);
        rst = r; in_sync = s; in_data = d; out_sync = o;
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_q.delete(); m_sum = 0; m_max = 0; m_ovf = 0;
        end else if (!m_pend) begin
            if (s) begin
                m_q.push_back(d);
                if (m_q.size() == 5) begin
                    model_block();
                    m_pend = 1;
                    m_q.delete();
                end
            end
        end else if (o) begin
            m_pend = 0;
        end
        #1;
    endtask

    task automatic step1(input logic s, input logic [31:0] d, input logic o);
        rst = 0; in_sync = 0; out_sync = 0;
        d1_in_sync = s; d1_in_data = d; d1_out_sync = o;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 32'h1234, 1);
        step(1, 0, 0, 0);
        checks++;
        if ({in_notify, out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset5 got in=%b out=%b ovf=%b sum=%h max=%h want 1 0 0 0 0",
                     in_notify, out_notify, ovf_out, sum_out, max_out);
        end
        checks++;
        if ({d1_in_notify, d1_out_notify, d1_ovf_out, d1_sum_out, d1_max_out} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset1 got in=%b out=%b ovf=%b sum=%h max=%h want 1 0 0 0 0",
                     d1_in_notify, d1_out_notify, d1_ovf_out, d1_sum_out, d1_max_out);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 32'(i), 1);
            checks++;
            if (out_notify !== (i == 5)) begin
                errors++;
                $display("FAIL basic_notify word %0d got out_notify=%b want %b", i, out_notify, (i == 5));
            end
        end
        checks++;
        if ({in_notify, ovf_out, sum_out, max_out} !== {1'b0, 1'b0, 32'd15, 32'd5}) begin
            errors++;
            $display("FAIL basic_result got in=%b ovf=%b sum=%0d max=%0d want 0 0 15 5", in_notify, ovf_out, sum_out, max_out);
        end
        step(0, 1, 32'd77, 1);
        checks++;
        if ({in_notify, out_notify, sum_out, max_out} !== {1'b1, 1'b0, 32'd15, 32'd5}) begin
            errors++;
            $display("FAIL basic_after got in=%b out=%b sum=%0d max=%0d want 1 0 15 5", in_notify, out_notify, sum_out, max_out);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w[5];
        w = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0};
        foreach (w[i]) step(0, 1, w[i], 0);
        checks++;
        if ({out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL ovf_block got out=%b ovf=%b sum=%h max=%h want 1 1 00000001 ffffffff", out_notify, ovf_out, sum_out, max_out);
        end
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 32'd1, 0);
        checks++;
        if ({out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b0, 32'd5, 32'd1}) begin
            errors++;
            $display("FAIL ovf_next got out=%b ovf=%b sum=%h max=%h want 1 0 5 1", out_notify, ovf_out, sum_out, max_out);
        end
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 32'd0, 0);
        checks++;
        if ({out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL zero_block got out=%b ovf=%b sum=%h max=%h want 1 0 0 0", out_notify, ovf_out, sum_out, max_out);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [31:0] w[5];
        w = '{32'd3, 32'd8, 32'd2, 32'd8, 32'd4};
        foreach (w[i]) step(0, 1, w[i], 0);
        for (int c = 0; c < 10; c++) begin
            step(0, c[0], 32'd7, 0);
            checks++;
            if ({in_notify, out_notify, ovf_out, sum_out, max_out} !== {1'b0, 1'b1, 1'b0, 32'd25, 32'd8}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got in=%b out=%b ovf=%b sum=%0d max=%0d want 0 1 0 25 8",
                         c, in_notify, out_notify, ovf_out, sum_out, max_out);
            end
        end
        step(0, 1, 32'd7, 1);
        checks++;
        if ({in_notify, out_notify} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got in=%b out=%b want 1 0", in_notify, out_notify);
        end
        for (int i = 1; i <= 5; i++) step(0, 1, 32'(i), 0);
        checks++;
        if ({out_notify, sum_out, max_out} !== {1'b1, 32'd15, 32'd5}) begin
            errors++;
            $display("FAIL bp_next got out=%b sum=%0d max=%0d want 1 15 5", out_notify, sum_out, max_out);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset_abort();
        step(0, 1, 32'd10, 0);
        step(0, 1, 32'd20, 0);
        step(0, 1, 32'd30, 0);
        step(1, 1, 32'd40, 1);
        checks++;
        if ({in_notify, out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b0, 1'b0, 32'd15, 32'd5} &&
            {in_notify, out_notify, ovf_out, sum_out, max_out} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
        end
        if ({in_notify, out_notify, sum_out, max_out} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL abort_reset got in=%b out=%b sum=%0d max=%0d want 1 0 0 0", in_notify, out_notify, sum_out, max_out);
        end
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 32'(i), 0);
            checks++;
            if (out_notify !== (i == 5)) begin
                errors++;
                $display("FAIL abort_notify word %0d got %b want %b", i, out_notify, (i == 5));
            end
        end
        checks++;
        if ({sum_out, max_out, ovf_out} !== {32'd15, 32'd5, 1'b0}) begin
            errors++;
            $display("FAIL abort_result got sum=%0d max=%0d ovf=%b want 15 5 0", sum_out, max_out, ovf_out);
        end
        step(1, 0, 0, 1);
        checks++;
        if ({in_notify, out_notify, sum_out, max_out} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL send_reset got in=%b out=%b sum=%0d max=%0d want 1 0 0 0", in_notify, out_notify, sum_out, max_out);
        end
    endtask

    task automatic test_random();
        logic r, s, o;
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            step(r, s, d, o);
            checks++;
            if ({in_notify, out_notify, ovf_out, sum_out, max_out} !== {~m_pend, m_pend, m_ovf, m_sum, m_max}) begin
                errors++;
                $display("FAIL random cycle %0d got in=%b out=%b ovf=%b sum=%h max=%h want %b %b %b %h %h",
                         c, in_notify, out_notify, ovf_out, sum_out, max_out, ~m_pend, m_pend, m_ovf, m_sum, m_max);
            end
        end
    endtask

    task automatic test_len1();
        logic [31:0] w[4];
        w = '{32'd9, 32'd4, $urandom, $urandom};
        foreach (w[i]) begin
            step1(1, w[i], 1);
            checks++;
            if ({d1_in_notify, d1_out_notify, d1_ovf_out, d1_sum_out, d1_max_out} !== {1'b0, 1'b1, 1'b0, w[i], w[i]}) begin
                errors++;
                $display("FAIL len1_result %0d got in=%b out=%b ovf=%b sum=%h max=%h want 0 1 0 %h %h",
                         i, d1_in_notify, d1_out_notify, d1_ovf_out, d1_sum_out, d1_max_out, w[i], w[i]);
            end
            step1(1, 32'hDEAD_BEEF, 1);
            checks++;
            if ({d1_in_notify, d1_out_notify, d1_sum_out} !== {1'b1, 1'b0, w[i]}) begin
                errors++;
                $display("FAIL len1_release %0d got in=%b out=%b sum=%h want 1 0 %h",
                         i, d1_in_notify, d1_out_notify, d1_sum_out, w[i]);
            end
        end
    endtask

    initial begin
        rst = 1; in_sync = 0; in_data = 0; out_sync = 0;
        d1_in_sync = 0; d1_in_data = 0; d1_out_sync = 0;
        m_pend = 0; m_sum = 0; m_max = 0; m_ovf = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_len1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
